// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
//   Shared definitions for the load/store unit:
//   - RV32I funct3 size codes used on the core request and the memory bus
//   - FSM state encoding for the load/store unit
//   - helper that decides whether a request must be rejected before any
//     bus access (illegal size code or misaligned address)
// ---------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } lsu_state_t;

  // A request is rejected when its size code does not exist (011/110/111),
  // when a store asks for an unsigned size (only loads extend), or when the
  // address is not naturally aligned for the access size.
  function automatic logic lsu_req_rejected(input logic       is_store,
                                            input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
              (is_store && funct3[2]);
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// ---------------------------------------------------------------------------
// load_extract
//   Combinational lane selection and extension of a raw memory word for
//   byte and half-word loads. Word loads pass through unchanged.
// Ports:
//   word     in  32  raw word returned by memory
//   addr_lo  in   2  low byte-address bits of the load
//   funct3   in   3  load size code (lb/lh/lw/lbu/lhu)
//   data     out 32  lane-aligned, sign- or zero-extended result
// ---------------------------------------------------------------------------
module load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte lane (equivalent to word >> 8*addr_lo).
  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
  end

  // Pick the addressed half-word lane (word >> 16*addr_lo[1]).
  always_comb begin
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
  end

  // Extend according to the size code; anything else is treated as a word.
  always_comb begin
    data = word;
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h000000, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0000, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Initiator side of the unified memory bus. Accepts one load/store request
//   at a time from the core, checks legality, drives the memory bus and
//   absorbs the memory's one-cycle registered read latency. Loads are
//   lane-aligned and extended by load_extract; stores are passed unshifted
//   (the memory does lane placement).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake from the core
//   req_write                  1 = store, 0 = load
//   req_addr/req_wdata         byte address, store data
//   req_funct3                 RV32I size code
//   resp_valid/resp_ready      response handshake to the core
//   resp_rdata                 extended load data (0 for stores/errors)
//   resp_error                 request rejected, no bus access made
//   mem_read/mem_write         memory enables
//   mem_address                memory byte address
//   mem_write_data             unshifted store data
//   mem_funct3                 access size code for the memory
//   mem_read_data              registered word from memory
// ---------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_read_data
);

  lsu_state_t  state_q;
  lsu_state_t  state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;
  logic [31:0] rdata_q;
  logic        error_q;
  logic        handshake;
  logic        bad_req;
  logic [31:0] extracted;

  assign handshake = req_valid && req_ready;
  assign bad_req   = lsu_req_rejected(req_write, req_funct3, req_addr[1:0]);

  // State register. Reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The load/store decision is taken at the handshake, so
  // the direction of the access is encoded in the state itself.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          if (bad_req) begin
            state_d = RESP;
          end else if (req_write) begin
            state_d = WR;
          end else begin
            state_d = RD_ADDR;
          end
        end
      end
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: state_d = RESP;
      WR:      state_d = RESP;
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request and response registers. Bus-facing request registers are only
  // loaded for legal requests, so a rejected request leaves mem_address and
  // friends at their last driven values. The response data is cleared at
  // every handshake so stores and errors report zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      if (handshake) begin
        rdata_q <= '0;
        error_q <= bad_req;
        if (!bad_req) begin
          addr_q   <= req_addr;
          wdata_q  <= req_wdata;
          funct3_q <= req_funct3;
        end
      end
      if (state_q == RD_DATA) begin
        rdata_q <= extracted;
      end
    end
  end

  load_extract u_load_extract (
    .word    (mem_read_data),
    .addr_lo (addr_q[1:0]),
    .funct3  (funct3_q),
    .data    (extracted)
  );

  // Outputs are forced quiet while reset is high: the state register only
  // clears at the reset edge, so without this gating a store sitting in WR
  // would still present mem_write during the reset cycle.
  always_comb begin
    req_ready      = !reset && (state_q == IDLE);
    resp_valid     = !reset && (state_q == RESP);
    mem_read       = !reset && ((state_q == RD_ADDR) || (state_q == RD_DATA));
    mem_write      = !reset && (state_q == WR);
    resp_rdata     = reset ? 32'h0 : rdata_q;
    resp_error     = !reset && error_q;
    mem_address    = reset ? 32'h0 : addr_q;
    mem_write_data = reset ? 32'h0 : wdata_q;
    mem_funct3     = reset ? 3'b000 : funct3_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//   Directed, table-driven bench for load_store_unit with a small registered
//   memory model that performs byte/half-word lane placement on writes.
// ---------------------------------------------------------------------------
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:63];
  logic        mem_init;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic [31:0] exp_rdata;
    logic        exp_error;
    int          exp_latency;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_funct3     (req_funct3),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_error     (resp_error),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_funct3     (mem_funct3),
    .mem_read_data  (mem_read_data)
  );

  // Memory model: 64 words indexed by address bits [7:2], registered read
  // that only updates while mem_read is high, lane-placed writes.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4]  <= 32'hDEADBEEF;
      mem[8]  <= 32'h11223344;
      mem[12] <= 32'h55AA55AA;
      mem[63] <= 32'hCAFEF00D;
    end else begin
      if (mem_write) begin
        case (mem_funct3[1:0])
          2'b00:   mem[mem_address[7:2]][{mem_address[1:0], 3'b000} +: 8] <= mem_write_data[7:0];
          2'b01:   mem[mem_address[7:2]][{mem_address[1], 4'b0000} +: 16] <= mem_write_data[15:0];
          default: mem[mem_address[7:2]] <= mem_write_data;
        endcase
      end
      if (mem_read) mem_read_data <= mem[mem_address[7:2]];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Issue one request, measure latency and bus activity, optionally hold the
  // response for a few cycles, then accept it and confirm IDLE returns.
  task automatic applyStimulus(input string tag, input vec_t v, input int hold_cycles);
    int          cycles;
    int          rd_cnt;
    int          wr_cnt;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  wr_f3;
    bit          got;
    cycles = 0; rd_cnt = 0; wr_cnt = 0; got = 0;
    wr_addr = 32'h0; wr_data = 32'h0; wr_f3 = 3'b000;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = v.write;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    req_funct3 = v.funct3;
    checkOutput({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = ~v.write;
    req_addr   = 32'hA5A5A5A5;
    req_wdata  = 32'h5A5A5A5A;
    req_funct3 = 3'b111;
    while (!got && cycles < 10) begin
      @(negedge clk);
      cycles++;
      if (mem_read) rd_cnt++;
      if (mem_write) begin
        wr_cnt++;
        wr_addr = mem_address;
        wr_data = mem_write_data;
        wr_f3   = mem_funct3;
      end
      if (resp_valid) got = 1;
    end
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(v.exp_latency));
    checkOutput({tag, "_rdata"}, resp_rdata, v.exp_rdata);
    checkOutput({tag, "_error"}, {31'b0, resp_error}, {31'b0, v.exp_error});
    checkOutput({tag, "_rd_cycles"}, 32'(rd_cnt), (v.exp_error || v.write) ? 32'd0 : 32'd2);
    checkOutput({tag, "_wr_cycles"}, 32'(wr_cnt), (!v.exp_error && v.write) ? 32'd1 : 32'd0);
    if (v.write && !v.exp_error) begin
      checkOutput({tag, "_wr_addr"}, wr_addr, v.addr);
      checkOutput({tag, "_wr_data"}, wr_data, v.wdata);
      checkOutput({tag, "_wr_funct3"}, {29'b0, wr_f3}, {29'b0, v.funct3});
    end
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, {31'b0, resp_valid}, 32'd1);
      checkOutput({tag, "_hold_rdata"}, resp_rdata, v.exp_rdata);
      checkOutput({tag, "_hold_req_ready"}, {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_back_to_idle"}, {31'b0, req_ready}, 32'd1);
    checkOutput({tag, "_resp_dropped"}, {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    reset      = 1'b1;
    mem_init   = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_funct3 = 3'b000;
    resp_ready = 1'b0;

    // write, addr, wdata, funct3, exp_rdata, exp_error, exp_latency
    vecs.push_back('{1'b0, 32'h00000010, 32'h0,        F3_W,   32'hDEADBEEF, 1'b0, 3});
    vecs.push_back('{1'b1, 32'h00000010, 32'h80FF7F01, F3_W,   32'h00000000, 1'b0, 2});
    vecs.push_back('{1'b0, 32'h00000010, 32'h0,        F3_W,   32'h80FF7F01, 1'b0, 3});
    vecs.push_back('{1'b0, 32'h00000013, 32'h0,        F3_B,   32'hFFFFFF80, 1'b0, 3});
    vecs.push_back('{1'b0, 32'h00000013, 32'h0,        F3_BU,  32'h00000080, 1'b0, 3});
    vecs.push_back('{1'b0, 32'h00000012, 32'h0,        F3_H,   32'hFFFF80FF, 1'b0, 3});
    vecs.push_back('{1'b0, 32'h00000010, 32'h0,        F3_HU,  32'h00007F01, 1'b0, 3});
    vecs.push_back('{1'b0, 32'h00000011, 32'h0,        F3_B,   32'h0000007F, 1'b0, 3});
    vecs.push_back('{1'b0, 32'h00000010, 32'h0,        F3_H,   32'h00007F01, 1'b0, 3});
    vecs.push_back('{1'b0, 32'h00000012, 32'h0,        F3_BU,  32'h000000FF, 1'b0, 3});
    vecs.push_back('{1'b0, 32'h00000012, 32'h0,        F3_B,   32'hFFFFFFFF, 1'b0, 3});
    vecs.push_back('{1'b1, 32'h00000022, 32'h0000ABCD, F3_H,   32'h00000000, 1'b0, 2});
    vecs.push_back('{1'b0, 32'h00000020, 32'h0,        F3_W,   32'hABCD3344, 1'b0, 3});
    vecs.push_back('{1'b1, 32'h00000021, 32'hFFFFFF5A, F3_B,   32'h00000000, 1'b0, 2});
    vecs.push_back('{1'b0, 32'h00000020, 32'h0,        F3_W,   32'hABCD5A44, 1'b0, 3});
    vecs.push_back('{1'b0, 32'h00000006, 32'h0,        F3_W,   32'h00000000, 1'b1, 1});
    vecs.push_back('{1'b1, 32'h00000003, 32'h0000FFFF, F3_H,   32'h00000000, 1'b1, 1});
    vecs.push_back('{1'b0, 32'h00000000, 32'h0,        3'b111, 32'h00000000, 1'b1, 1});
    vecs.push_back('{1'b0, 32'h00000000, 32'h0,        3'b011, 32'h00000000, 1'b1, 1});
    vecs.push_back('{1'b0, 32'h00000000, 32'h0,        3'b110, 32'h00000000, 1'b1, 1});
    vecs.push_back('{1'b1, 32'h00000010, 32'h000000EE, F3_BU,  32'h00000000, 1'b1, 1});
    vecs.push_back('{1'b0, 32'h00000011, 32'h0,        F3_HU,  32'h00000000, 1'b1, 1});
    vecs.push_back('{1'b0, 32'h00000012, 32'h0,        F3_W,   32'h00000000, 1'b1, 1});
    vecs.push_back('{1'b0, 32'hFFFFFFFC, 32'h0,        F3_W,   32'hCAFEF00D, 1'b0, 3});
    vecs.push_back('{1'b0, 32'hFFFFFFFF, 32'h0,        F3_BU,  32'h000000CA, 1'b0, 3});
    vecs.push_back('{1'b0, 32'hFFFFFFFE, 32'h0,        F3_H,   32'hFFFFCAFE, 1'b0, 3});

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_mem_read", {31'b0, mem_read}, 32'd0);
    checkOutput("rst_mem_write", {31'b0, mem_write}, 32'd0);
    checkOutput("rst_mem_address", mem_address, 32'h0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    reset    = 1'b0;
    mem_init = 1'b0;
    #1;
    checkOutput("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i], 0);
    end

    // Response held for five cycles with resp_ready low.
    v = '{1'b0, 32'h00000020, 32'h0, F3_W, 32'hABCD5A44, 1'b0, 3};
    applyStimulus("hold", v, 5);

    // Reset while a store sits in WR: the write must not reach memory.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30;
    req_wdata = 32'h12345678; req_funct3 = F3_W;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("wr_before_reset", {31'b0, mem_write}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("wr_reset_mem_write", {31'b0, mem_write}, 32'd0);
    checkOutput("wr_reset_req_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("wr_reset_mem_address", mem_address, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("wr_after_reset_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("wr_after_reset_resp_valid", {31'b0, resp_valid}, 32'd0);
    v = '{1'b0, 32'h00000030, 32'h0, F3_W, 32'h55AA55AA, 1'b0, 3};
    applyStimulus("store_aborted", v, 0);

    // Reset while a load sits in RD_DATA.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
    req_wdata = 32'h0; req_funct3 = F3_W;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rd_addr_mem_read", {31'b0, mem_read}, 32'd1);
    @(negedge clk);
    checkOutput("rd_data_mem_read", {31'b0, mem_read}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rd_reset_mem_read", {31'b0, mem_read}, 32'd0);
    checkOutput("rd_reset_resp_rdata", resp_rdata, 32'h0);
    checkOutput("rd_reset_mem_address", mem_address, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rd_after_reset_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rd_after_reset_resp_valid", {31'b0, resp_valid}, 32'd0);
    v = '{1'b0, 32'h00000013, 32'h0, F3_B, 32'hFFFFFF80, 1'b0, 3};
    applyStimulus("after_rd_reset", v, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
